// File: rtl/rv_pipe_pkg.sv
// Shared fetch/decode pipeline types and constants.
package rv_pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifq_storage.sv
// Instruction queue entry array: one write port, one asynchronous read port.
module ifq_storage
    import rv_pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output fetch_entry_t rdata
);

    fetch_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch-to-decode instruction queue with flush; IFQ_BYPASS_EN enables
// a zero-latency path from in_* to out_* while the queue is empty.
module instr_fetch_queue
    import rv_pipe_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR,
    parameter int          PW        = $clog2(DEPTH),
    parameter int          CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_instr,
    output logic          in_ready,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    input  logic          out_ready,
    output logic [CW-1:0] count
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          empty;
    logic          bypass;
    logic          push;
    logic          pop;
    fetch_entry_t  wr_entry;
    fetch_entry_t  rd_entry;
    fetch_entry_t  head;

    assign empty    = (cnt == '0);
    assign in_ready = (cnt != CW'(DEPTH));
    assign count    = cnt;

`ifdef IFQ_BYPASS_EN
    assign bypass = empty & in_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = (~empty | bypass) & ~flush;
    assign wr_entry  = '{pc: in_pc, instr: in_instr};
    assign head      = bypass ? wr_entry : rd_entry;
    assign out_pc    = out_valid ? head.pc : 32'h0;
    assign out_instr = out_valid ? head.instr : NOP_INSTR;

    // A bypassed beat consumed by decode never touches storage.
    assign push = in_valid & in_ready & ~flush & ~(bypass & out_ready);
    assign pop  = out_valid & out_ready & ~bypass;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    ifq_storage #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed plan steps plus random traffic
// against a queue-based reference model (honours IFQ_BYPASS_EN).
module tb_instr_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;

    logic [63:0] q[$];

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive, check combinational outputs, clock, update model, check count.
    task automatic step(input logic v, input logic [31:0] pc,
                        input logic [31:0] ins, input logic ordy,
                        input logic fl);
        int          n;
        bit          byp;
        bit          ev;
        bit          acc;
        logic [31:0] epc;
        logic [31:0] eins;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        #1;
        n = q.size();
`ifdef IFQ_BYPASS_EN
        byp = (n == 0) && v && !fl;
`else
        byp = 1'b0;
`endif
        ev   = (n != 0 || byp) && !fl;
        epc  = !ev ? 32'h0 : (byp ? pc : q[0][63:32]);
        eins = !ev ? NOP : (byp ? ins : q[0][31:0]);
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("out_pc", 64'(out_pc), 64'(epc));
        chk("out_instr", 64'(out_instr), 64'(eins));
        chk("in_ready", 64'(in_ready), 64'(n != DEPTH));
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            acc = v && (n != DEPTH);
            if (ev && ordy && !byp) void'(q.pop_front());
            if (acc && !(byp && ordy)) q.push_back({pc, ins});
        end
        #1;
        chk("count", 64'(count), 64'(q.size()));
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 32'h0, ordy, 1'b0);
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'h13);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single entry
        step(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
        idle(1'b0);
        chk("single_pc", 64'(out_pc), 64'h0);
        chk("single_valid", 64'(out_valid), 64'd1);
        idle(1'b1);

        // Fill to full, 5th beat dropped, drain in order
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'b0, 1'b0);
        chk("full_count", 64'(count), 64'd4);
        for (int i = 0; i < 5; i++) idle(1'b1);
        chk("drained", 64'(count), 64'd0);

        // Steady stream
        for (int i = 0; i < 10; i++)
            step(1'b1, 32'(i * 4), 32'h2000 + 32'(i), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) idle(1'b1);

        // Wrap-around: advance pointers by 3, then push 4, pop 4
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h200 + 32'(i * 4), 32'h3000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h300 + 32'(i * 4), 32'h4000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Flush with count 3 and a beat offered
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h20 + 32'(i * 4), 32'h5000 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'h40, 32'h5555, 1'b1, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        step(1'b1, 32'h80, 32'h6000, 1'b0, 1'b0);
        idle(1'b1);

`ifdef IFQ_BYPASS_EN
        step(1'b1, 32'h100, 32'h7000, 1'b1, 1'b0);
        chk("byp_count0", 64'(count), 64'd0);
        step(1'b1, 32'h104, 32'h7001, 1'b0, 1'b0);
        chk("byp_count1", 64'(count), 64'd1);
        idle(1'b1);
`endif

        // Asynchronous reset mid-cycle with data held
        for (int i = 0; i < 2; i++)
            step(1'b1, 32'h900 + 32'(i * 4), 32'h8000 + 32'(i), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        q.delete();
        chk("async_count", 64'(count), 64'd0);
        chk("async_valid", 64'(out_valid), 64'd0);
        chk("async_instr", 64'(out_instr), 64'h13);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 32'h1000 + 32'(i * 4), $urandom,
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
